// File: rtl/bg_pkg.sv
// Shared definitions for the background scanner and the sprite drawers.
// Contents: scanner FSM state type, default coordinate and colour widths,
// screen extent and named colours.
package bg_pkg;

    localparam int unsigned BG_COORD_W  = 9;
    localparam int unsigned BG_COLOUR_W = 3;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;

    localparam logic [BG_COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [BG_COLOUR_W-1:0] WHITE = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWrite,
        StDone
    } bg_state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster-order x/y counter.
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-high reset, clears to (0, 0)
//   clear_i    synchronous clear to (0, 0), wins over advance_i
//   advance_i  step one pixel in raster order; holds on the last pixel
//   x_o, y_o   current coordinate
//   x_last_o   x is on the last column
//   y_last_o   y is on the last row
module raster_counter
    import bg_pkg::*;
#(
    parameter int unsigned COORD_W = BG_COORD_W,
    parameter int unsigned X_LAST  = SCREEN_W - 1,
    parameter int unsigned Y_LAST  = SCREEN_H - 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               advance_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               x_last_o,
    output logic               y_last_o
);

    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign x_last_o = (x_q == COORD_W'(X_LAST));
    assign y_last_o = (y_q == COORD_W'(Y_LAST));

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clear_i) begin
            x_d = '0;
            y_d = '0;
        end else if (advance_i && !(x_last_o && y_last_o)) begin
            // Stepping past the final pixel is a no-op: the frame end is held.
            if (x_last_o) begin
                x_d = '0;
                y_d = y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/background_scanner.sv
// Background redraw sequencer: sweeps the screen in raster order, feeds each
// coordinate to the background renderer, captures the returned colour after
// RENDER_LATENCY edges and issues one plot write per pixel to the VGA adapter.
// Ports:
//   clock, reset                 clock; asynchronous active-high reset
//   start / busy / done          handshake with the game control FSM
//   x_cord, y_cord, colour_in    renderer coordinate out, colour back
//   plot_x, plot_y, plot_colour  VGA write data
//   plot / plot_ready            VGA write request, held until accepted
// Build option: define BACKGROUND_SKIP_BLACK_EN to skip writing black pixels
// (useful when the framebuffer is already cleared).
module background_scanner
    import bg_pkg::*;
#(
    parameter int unsigned COORD_W        = BG_COORD_W,
    parameter int unsigned COLOUR_W       = BG_COLOUR_W,
    parameter int unsigned X_LAST         = SCREEN_W - 1,
    parameter int unsigned Y_LAST         = SCREEN_H - 1,
    parameter int unsigned RENDER_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [COORD_W-1:0]  x_cord,
    output logic [COORD_W-1:0]  y_cord,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic                plot,
    input  logic                plot_ready
);

    localparam int unsigned WaitW = (RENDER_LATENCY > 1) ? $clog2(RENDER_LATENCY) : 1;

    bg_state_e           state_q;
    logic [WaitW-1:0]    wait_q;
    logic [COORD_W-1:0]  plot_x_q;
    logic [COORD_W-1:0]  plot_y_q;
    logic [COLOUR_W-1:0] plot_colour_q;
    logic                plot_q;
    logic                busy_q;
    logic                done_q;

    logic [COORD_W-1:0]  scan_x;
    logic [COORD_W-1:0]  scan_y;
    logic                scan_x_last;
    logic                scan_y_last;
    logic                frame_last;
    logic                scan_clear;
    logic                scan_advance;
    logic                wait_end;
    logic                skip_pixel;

    assign frame_last = scan_x_last && scan_y_last;
    assign wait_end   = (state_q == StWait) && (wait_q == '0);

    always_comb begin
`ifdef BACKGROUND_SKIP_BLACK_EN
        skip_pixel = (colour_in == '0);
`else
        skip_pixel = 1'b0;
`endif
        scan_clear   = (state_q == StIdle) && start;
        // A skipped pixel advances exactly as if its write had been accepted.
        scan_advance = ((state_q == StWrite) && plot_ready) || (wait_end && skip_pixel);
    end

    raster_counter #(
        .COORD_W(COORD_W),
        .X_LAST (X_LAST),
        .Y_LAST (Y_LAST)
    ) u_raster (
        .clk_i    (clock),
        .rst_i    (reset),
        .clear_i  (scan_clear),
        .advance_i(scan_advance),
        .x_o      (scan_x),
        .y_o      (scan_y),
        .x_last_o (scan_x_last),
        .y_last_o (scan_y_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            wait_q        <= '0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        busy_q  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    wait_q  <= WaitW'(RENDER_LATENCY - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WaitW'(1);
                    end else if (skip_pixel) begin
                        done_q  <= frame_last;
                        state_q <= frame_last ? StDone : StIssue;
                    end else begin
                        plot_colour_q <= colour_in;
                        plot_x_q      <= scan_x;
                        plot_y_q      <= scan_y;
                        plot_q        <= 1'b1;
                        state_q       <= StWrite;
                    end
                end
                StWrite: begin
                    if (plot_ready) begin
                        plot_q  <= 1'b0;
                        done_q  <= frame_last;
                        state_q <= frame_last ? StDone : StIssue;
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign x_cord      = scan_x;
    assign y_cord      = scan_y;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = plot_colour_q;
    assign plot        = plot_q;

endmodule

// File: tb/tb_background_scanner.sv
// Bench for background_scanner on a 4x2 frame. Two instances: latency 1 and
// latency 3, each fed by its own renderer model.
module tb_background_scanner;

    localparam int XL   = 3;
    localparam int YL   = 1;
    localparam int NPIX = (XL + 1) * (YL + 1);

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       plot_ready = 1'b1;
    logic       sel = 1'b0;
    int         mode = 0;
    int         total = 0;
    int         bad = 0;

    logic       start1, start3;
    logic       busy1, done1, plot1, busy3, done3, plot3;
    logic [8:0] x1, y1, px1, py1, x3, y3, px3, py3;
    logic [2:0] pc1, pc3, colour1, colour3, r3a, r3b;

    logic       o_busy, o_done, o_plot;
    logic [8:0] o_xc, o_yc, o_px, o_py;
    logic [2:0] o_pc;

    always #5 clock = ~clock;

    assign start1 = start & ~sel;
    assign start3 = start & sel;
    assign o_busy = sel ? busy3 : busy1;
    assign o_done = sel ? done3 : done1;
    assign o_plot = sel ? plot3 : plot1;
    assign o_xc   = sel ? x3 : x1;
    assign o_yc   = sel ? y3 : y1;
    assign o_px   = sel ? px3 : px1;
    assign o_py   = sel ? py3 : py1;
    assign o_pc   = sel ? pc3 : pc1;

    // Renderer: mode 0 returns {x[0], y[0], 1}; mode 1 returns black for even x.
    function automatic logic [2:0] render(input logic [8:0] x, input logic [8:0] y);
        if (mode == 1 && x[0] == 1'b0) return 3'b000;
        return {x[0], y[0], 1'b1};
    endfunction

    function automatic bit is_skipped(input int i);
`ifdef BACKGROUND_SKIP_BLACK_EN
        return (mode == 1) && ((i % (XL + 1)) % 2 == 0);
`else
        return (i < 0);
`endif
    endfunction

    always @(posedge clock) begin
        colour1 <= render(x1, y1);
        r3a     <= render(x3, y3);
        r3b     <= r3a;
        colour3 <= r3b;
    end

    background_scanner #(
        .COORD_W(9), .COLOUR_W(3), .X_LAST(XL), .Y_LAST(YL), .RENDER_LATENCY(1)
    ) dut (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .x_cord(x1), .y_cord(y1), .colour_in(colour1), .plot_x(px1), .plot_y(py1),
        .plot_colour(pc1), .plot(plot1), .plot_ready(plot_ready)
    );

    background_scanner #(
        .COORD_W(9), .COLOUR_W(3), .X_LAST(XL), .Y_LAST(YL), .RENDER_LATENCY(3)
    ) dut3 (
        .clock(clock), .reset(reset), .start(start3), .busy(busy3), .done(done3),
        .x_cord(x3), .y_cord(y3), .colour_in(colour3), .plot_x(px3), .plot_y(py3),
        .plot_colour(pc3), .plot(plot3), .plot_ready(plot_ready)
    );

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++;
        if ({busy1, done1, plot1, busy3, done3, plot3} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {busy1, done1, plot1, busy3, done3, plot3});
        end
        total++;
        if ({x1, y1, px1, py1, pc1} !== 39'b0) begin
            bad++;
            $display("FAIL reset_data: got x=%0d y=%0d px=%0d py=%0d pc=%0d expected all 0",
                     x1, y1, px1, py1, pc1);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if ({busy1, plot1, x1, y1} !== 20'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b plot=%b x=%0d y=%0d expected 0",
                     busy1, plot1, x1, y1);
        end
    endtask

    // Runs one frame from the current negedge; checks every write (order,
    // data, cycle of appearance), optional stall, and the done pulse timing.
    task automatic run_frame(input bit use3, input int rl, input int stall_idx,
                             input int stall_len, input bit poke_start);
        int cyc, idx, nsk, acc_cyc, exp_t, done_exp, nwr, exp_nwr, held;
        bit done_seen, stalling;
        logic [8:0] ex, ey;
        logic [2:0] ec;
        sel = use3;
        exp_nwr = 0;
        for (int i = 0; i < NPIX; i++) if (!is_skipped(i)) exp_nwr++;
        idx = 0; acc_cyc = 0; nwr = 0; held = 0; done_seen = 0; stalling = 0;
        done_exp = -1; exp_t = -1; nsk = 0;
        while (idx < NPIX && is_skipped(idx)) begin idx++; nsk++; end
        if (idx < NPIX) exp_t = acc_cyc + (1 + rl) * nsk + 2 + rl;
        else done_exp = acc_cyc + 1 + (1 + rl) * nsk;

        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        cyc = 1;
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_start: got %b expected 1", o_busy);
        end
        while (!done_seen && cyc < 200) begin
            start = poke_start && (cyc == 5);
            if (stalling && o_plot !== 1'b1) begin
                total++; bad++;
                $display("FAIL plot_held: got plot=%b expected 1 at cycle %0d", o_plot, cyc);
            end
            if (o_plot === 1'b1) begin
                ex = 9'(idx % (XL + 1));
                ey = 9'(idx / (XL + 1));
                ec = (mode == 1 && !ex[0]) ? 3'b000 : {ex[0], ey[0], 1'b1};
                if (held == 0) begin
                    total++;
                    if (cyc != exp_t) begin
                        bad++;
                        $display("FAIL plot_time: got cycle %0d expected %0d", cyc, exp_t);
                    end
                end
                total++;
                if (idx >= NPIX || o_px !== ex || o_py !== ey || o_pc !== ec ||
                    o_xc !== ex || o_yc !== ey) begin
                    bad++;
                    $display("FAIL pixel: got (%0d,%0d) c=%0d cord=(%0d,%0d) expected (%0d,%0d) c=%0d",
                             o_px, o_py, o_pc, o_xc, o_yc, ex, ey, ec);
                end
                if (idx == stall_idx && held < stall_len) begin
                    plot_ready = 1'b0;
                    stalling = 1;
                    held++;
                end else begin
                    plot_ready = 1'b1;
                    stalling = 0;
                    held = 0;
                    nwr++;
                    acc_cyc = cyc;
                    idx++;
                    nsk = 0;
                    while (idx < NPIX && is_skipped(idx)) begin idx++; nsk++; end
                    if (idx < NPIX) exp_t = acc_cyc + (1 + rl) * nsk + 2 + rl;
                    else done_exp = acc_cyc + 1 + (1 + rl) * nsk;
                end
            end
            if (o_done === 1'b1) begin
                done_seen = 1;
                total++;
                if (cyc != done_exp || nwr != exp_nwr) begin
                    bad++;
                    $display("FAIL done_time: got cycle %0d writes %0d expected cycle %0d writes %0d",
                             cyc, nwr, done_exp, exp_nwr);
                end
                start = poke_start;
            end
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        plot_ready = 1'b1;
        total++;
        if (!done_seen) begin
            bad++;
            $display("FAIL frame_timeout: got no done in %0d cycles expected done", cyc);
        end else if ({o_done, o_busy, o_plot} !== 3'b000) begin
            bad++;
            $display("FAIL after_done: got done=%b busy=%b plot=%b expected 000",
                     o_done, o_busy, o_plot);
        end
    endtask

    task automatic test_small_frame();
        run_frame(1'b0, 1, -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_frame(1'b0, 1, 2, 5, 1'b0);
    endtask

    task automatic test_latency3();
        run_frame(1'b1, 3, -1, 0, 1'b0);
    endtask

    // Starts during busy and on the DONE cycle are ignored; a start in the
    // cycle right after DONE begins a fresh frame at (0,0).
    task automatic test_start_ignored();
        run_frame(1'b0, 1, -1, 0, 1'b1);
        run_frame(1'b0, 1, -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid_write();
        bit found;
        found = 0;
        sel = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (plot1 === 1'b1 && px1 == 9'd1 && py1 == 9'd1) begin
                plot_ready = 1'b0;
                found = 1;
            end else begin
                @(negedge clock);
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL reach_pixel_1_1: got no write of (1,1) expected one");
        end
        @(posedge clock);
        #2;
        total++;
        if (plot1 !== 1'b1) begin
            bad++;
            $display("FAIL hold_before_reset: got plot=%b expected 1", plot1);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({plot1, busy1, done1} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset: got plot=%b busy=%b done=%b expected 000",
                     plot1, busy1, done1);
        end
        @(negedge clock);
        reset = 1'b0;
        plot_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            total++;
            if ({plot1, busy1, done1} !== 3'b000 || x1 !== 9'd0 || y1 !== 9'd0) begin
                bad++;
                $display("FAIL quiet_after_reset: got plot=%b busy=%b done=%b x=%0d y=%0d expected 0",
                         plot1, busy1, done1, x1, y1);
            end
        end
    endtask

    task automatic test_black_pixels();
        mode = 1;
        run_frame(1'b0, 1, -1, 0, 1'b0);
        run_frame(1'b1, 3, -1, 0, 1'b0);
        mode = 0;
    endtask

    initial begin
        test_reset();
        test_small_frame();
        test_backpressure();
        test_latency3();
        test_start_ignored();
        test_reset_mid_write();
        test_black_pixels();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
